// File: rtl/lcd_bus_if.sv
// Requester handshake and LCD pin bundle for the character LCD bus scheduler.
// The master modport is the requester/pin side; the slave modport is the scheduler.
interface lcd_bus_if;
    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       RS;
    logic       RW;
    logic       E;
    logic [7:0] data;
    logic       init_done;
    logic       busy;

    modport master (
        output req0_valid, req0_rs, req0_data,
        output req1_valid, req1_rs, req1_data,
        input  req0_ready, req1_ready,
        input  RS, RW, E, data, init_done, busy
    );

    modport slave (
        input  req0_valid, req0_rs, req0_data,
        input  req1_valid, req1_rs, req1_data,
        output req0_ready, req1_ready,
        output RS, RW, E, data, init_done, busy
    );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// HD44780-style 8-bit LCD bus owner: power-up init sequence, then round-robin
// sharing of the bus between two valid/ready requesters with exact E/exec timing.
module lcd_bus_scheduler #(
    parameter int T_POWERUP = 7500000,
    parameter int T_E_HIGH  = 25,
    parameter int T_CMD     = 2500,
    parameter int T_CLEAR   = 100000,
    parameter int CNT_W     = 23
) (
    input  logic     clk,
    input  logic     rst,
    lcd_bus_if.slave bus
);
    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        PULSE,
        EXEC
    } state_t;

    localparam logic [CNT_W-1:0] L_POWERUP = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] L_E_HIGH  = CNT_W'(T_E_HIGH - 1);
    localparam logic [CNT_W-1:0] L_CMD     = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] L_CLEAR   = CNT_W'(T_CLEAR - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_limit;
    logic             r_rs;
    logic [7:0]       r_data;
    logic [1:0]       r_init_idx;
    logic             r_init_done;
    logic             r_last_grant;
    logic             w_expired;
    logic             w_long_wait;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_e;
    logic             w_busy;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    init_rom = 8'h38;
            2'd1:    init_rom = 8'h0C;
            2'd2:    init_rom = 8'h06;
            default: init_rom = 8'h01;
        endcase
    endfunction

    // Clear and home are the only slow commands; the same bytes sent as data are not.
    assign w_long_wait = !r_rs && (r_data == 8'h01 || r_data == 8'h02);

    always_comb begin
        w_limit = '0;
        case (r_state)
            PWR_WAIT: w_limit = L_POWERUP;
            PULSE:    w_limit = L_E_HIGH;
            EXEC:     w_limit = w_long_wait ? L_CLEAR : L_CMD;
            default:  ;
        endcase
    end

    // Timer counts elapsed cycles in the current state, so dwell = limit + 1.
    assign w_expired = (r_timer == w_limit);

    // On a tie the requester that did not win last time is served.
    assign w_grant0 = r_init_done && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1 = r_init_done && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    always_comb begin
        w_next   = r_state;
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        w_e      = 1'b0;
        w_busy   = 1'b1;
        case (r_state)
            PWR_WAIT:  if (w_expired) w_next = INIT_LOAD;
            INIT_LOAD: w_next = SETUP;
            IDLE: begin
                w_busy   = 1'b0;
                w_ready0 = w_grant0;
                w_ready1 = w_grant1;
                if (w_grant0 || w_grant1) w_next = SETUP;
            end
            SETUP:     w_next = PULSE;
            PULSE: begin
                w_e = 1'b1;
                if (w_expired) w_next = EXEC;
            end
            EXEC: begin
                if (w_expired)
                    w_next = (!r_init_done && r_init_idx != 2'd3) ? INIT_LOAD : IDLE;
            end
            default:   w_next = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PWR_WAIT;
            r_timer      <= '0;
            r_rs         <= 1'b0;
            r_data       <= 8'h00;
            r_init_idx   <= 2'd0;
            r_init_done  <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            r_timer <= (w_next != r_state || r_state == IDLE) ? '0 : r_timer + CNT_W'(1);
            case (r_state)
                INIT_LOAD: begin
                    r_rs   <= 1'b0;
                    r_data <= init_rom(r_init_idx);
                end
                IDLE: begin
                    if (w_grant0) begin
                        r_rs         <= bus.req0_rs;
                        r_data       <= bus.req0_data;
                        r_last_grant <= 1'b0;
                    end else if (w_grant1) begin
                        r_rs         <= bus.req1_rs;
                        r_data       <= bus.req1_data;
                        r_last_grant <= 1'b1;
                    end
                end
                EXEC: begin
                    if (w_expired && !r_init_done) begin
                        if (r_init_idx == 2'd3) r_init_done <= 1'b1;
                        else                    r_init_idx  <= r_init_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.RS         = r_rs;
    assign bus.RW         = 1'b0;
    assign bus.E          = w_e;
    assign bus.data       = r_data;
    assign bus.init_done  = r_init_done;
    assign bus.busy       = w_busy;
    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
endmodule
